mdio_txn_scheduler: RTL and testbench

// Shares one MDIO management controller (mdio_start/t_data/rd_data/data_rdy) between NREQ requesters.

---
 rtl/mdio_txn_scheduler.sv | 139 +++++++++++++
 tb/tb_mdio_txn_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_txn_scheduler.sv
// Round-robin scheduler that shares one MDIO controller between NREQ requesters.
// It runs one Clause-22 frame at a time and returns read data or a timeout error.
module mdio_txn_scheduler #(
    parameter int NREQ         = 4,
    parameter int FRAME_CLKS   = 128,
    parameter int TIMEOUT_CLKS = 256,
    parameter int GAP_CLKS     = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ-1:0]      req_write_i,
    input  logic [5*NREQ-1:0]    req_phyad_i,
    input  logic [5*NREQ-1:0]    req_regad_i,
    input  logic [16*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [15:0]          rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 busy_o,
    output logic                 mdio_start_o,
    output logic [31:0]          t_data_o,
    input  logic [15:0]          rd_data_i,
    input  logic                 data_rdy_i
);
    localparam int MAX_FT = (FRAME_CLKS > TIMEOUT_CLKS) ? FRAME_CLKS : TIMEOUT_CLKS;
    localparam int MAXC   = (MAX_FT > GAP_CLKS) ? MAX_FT : GAP_CLKS;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_WR, WAIT_RD, RESP, GAP} state_e;

    state_e                   state_q;
    logic [PW-1:0]            rr_q;
    logic [PW-1:0]            win_d;
    logic                     grant_d;
    logic                     wr_q;
    logic [4:0]               phy_q, reg_q;
    logic [15:0]              wdata_q;
    logic [CW-1:0]            cnt_q, cnt_inc;
    logic [NREQ-1:0][4:0]     phy_arr, reg_arr;
    logic [NREQ-1:0][15:0]    wdata_arr;

    assign phy_arr   = req_phyad_i;
    assign reg_arr   = req_regad_i;
    assign wdata_arr = req_wdata_i;

    // Scan starts just past the last winner, so the previous winner is tried last.
    always_comb begin
        logic [PW-1:0] idx;
        win_d   = rr_q;
        grant_d = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(rr_q) + k) % NREQ);
            if (!grant_d && req_valid_i[idx]) begin
                grant_d = 1'b1;
                win_d   = idx;
            end
        end
    end

    // Acceptance is signalled in the same cycle the request fields are sampled.
    assign req_ready_o = (state_q == IDLE && grant_d && !reset_i) ? (NREQ'(1) << win_d) : '0;
    assign busy_o      = (state_q != IDLE);
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            rr_q         <= PW'(NREQ - 1);
            wr_q         <= 1'b0;
            phy_q        <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rsp_valid_o  <= '0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
            mdio_start_o <= 1'b0;
            t_data_o     <= '0;
        end else begin
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        wr_q    <= req_write_i[win_d];
                        phy_q   <= phy_arr[win_d];
                        reg_q   <= reg_arr[win_d];
                        wdata_q <= wdata_arr[win_d];
                        rr_q    <= win_d;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    t_data_o     <= {2'b01, (wr_q ? 2'b01 : 2'b10), phy_q, reg_q,
                                     (wr_q ? 2'b10 : 2'b00), (wr_q ? wdata_q : 16'h0000)};
                    mdio_start_o <= 1'b1;
                    cnt_q        <= '0;
                    state_q      <= wr_q ? WAIT_WR : WAIT_RD;
                end
                WAIT_WR: begin
                    cnt_q <= cnt_inc;
                    if (cnt_q == CW'(FRAME_CLKS - 1)) begin
                        mdio_start_o <= 1'b0;
                        rsp_valid_o  <= NREQ'(1) << rr_q;
                        state_q      <= RESP;
                    end
                end
                WAIT_RD: begin
                    cnt_q <= cnt_inc;
                    // Data arriving on the expiry cycle still counts as a good read.
                    if (data_rdy_i) begin
                        mdio_start_o <= 1'b0;
                        rsp_valid_o  <= NREQ'(1) << rr_q;
                        rsp_rdata_o  <= rd_data_i;
                        state_q      <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT_CLKS - 1)) begin
                        mdio_start_o <= 1'b0;
                        rsp_valid_o  <= NREQ'(1) << rr_q;
                        rsp_err_o    <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    cnt_q   <= '0;
                    state_q <= GAP;
                end
                GAP: begin
                    cnt_q <= cnt_inc;
                    if (cnt_q == CW'(GAP_CLKS - 1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_txn_scheduler.sv
// Directed bench for mdio_txn_scheduler: a timestamp-based transaction model checks
// every cycle, plus literal checks on frames, lengths, responses and grant order.
module tb_mdio_txn_scheduler;
    localparam int NREQ = 4, FRAME = 128, TMO = 256, GAPC = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid, req_write;
    logic [5*NREQ-1:0]   req_phyad, req_regad;
    logic [16*NREQ-1:0]  req_wdata;
    logic [NREQ-1:0]     req_ready, rsp_valid;
    logic [15:0]         rsp_rdata, rd_data;
    logic                rsp_err, busy, mdio_start, data_rdy;
    logic [31:0]         t_data;

    mdio_txn_scheduler #(.NREQ(NREQ), .FRAME_CLKS(FRAME), .TIMEOUT_CLKS(TMO), .GAP_CLKS(GAPC)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_write_i(req_write),
        .req_phyad_i(req_phyad), .req_regad_i(req_regad), .req_wdata_i(req_wdata),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy), .mdio_start_o(mdio_start), .t_data_o(t_data),
        .rd_data_i(rd_data), .data_rdy_i(data_rdy));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] frame_of(input bit wr, input logic [4:0] p, input logic [4:0] r,
                                             input logic [15:0] d);
        logic [31:0] f;
        f = '0;
        f[31:30] = 2'b01;
        f[29:28] = wr ? 2'b01 : 2'b10;
        f[27:23] = p;
        f[22:18] = r;
        f[17:16] = wr ? 2'b10 : 2'b00;
        f[15:0]  = wr ? d : 16'h0000;
        return f;
    endfunction

    // Model: a transaction is described by its acceptance cycle, frame start (accept+2),
    // response cycle (frame end) and the last busy cycle (response + gap).
    bit          m_act;
    int          m_start, m_rsp, m_id, m_rr;
    bit          m_wr, m_err;
    logic [31:0] m_frame, m_last;
    logic [15:0] m_rdata;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_rr, e_rv;
        logic e_ms, e_busy;
        int w;
        if (reset) begin
            m_act = 0; m_rr = NREQ - 1; m_last = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_mdio_start", mdio_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_t_data", t_data, 0);
        end else begin
            e_rr = '0; e_rv = '0; e_ms = 0; e_busy = 0;
            if (m_act) begin
                e_busy = 1;
                if (cyc == m_start) m_last = m_frame;
                if (cyc >= m_start && m_rsp < 0) begin
                    e_ms = 1;
                    if (!m_wr && data_rdy) begin
                        m_rsp = cyc + 1; m_rdata = rd_data; m_err = 0;
                    end else if (cyc - m_start + 1 == (m_wr ? FRAME : TMO)) begin
                        m_rsp = cyc + 1; m_rdata = 16'h0; m_err = !m_wr;
                    end
                end else if (m_rsp >= 0 && cyc == m_rsp) begin
                    e_rv = NREQ'(1) << m_id;
                end
                if (m_rsp >= 0 && cyc == m_rsp + GAPC) m_act = 0;
            end else if (req_valid != 0) begin
                w = m_rr;
                for (int k = 1; k <= NREQ; k++) begin
                    if (req_valid[(m_rr + k) % NREQ]) begin
                        w = (m_rr + k) % NREQ;
                        break;
                    end
                end
                e_rr = NREQ'(1) << w;
                m_act = 1; m_start = cyc + 2; m_rsp = -1; m_id = w; m_rr = w;
                m_wr = req_write[w];
                m_frame = frame_of(req_write[w], req_phyad[5*w +: 5], req_regad[5*w +: 5],
                                   req_wdata[16*w +: 16]);
            end
            chk("req_ready", req_ready, e_rr);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("mdio_start", mdio_start, e_ms);
            chk("busy", busy, e_busy);
            chk("t_data", t_data, m_last);
            if (e_rv != 0) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", rsp_err, m_err);
            end
        end
    end

    // Observation: frame capture, high-time length, gap between frames, grant log.
    logic [31:0] cap_frame = '0;
    int  ms_len = 0, low_run = 0, min_gap = 1000000;
    bit  ms_prev = 0, seen_fall = 0;
    int  grants[$];

    always @(negedge clk) begin
        if (mdio_start && !ms_prev) begin
            cap_frame = t_data; ms_len = 0;
            if (seen_fall && low_run < min_gap) min_gap = low_run;
        end
        if (mdio_start) ms_len++;
        else begin
            if (ms_prev) begin seen_fall = 1; low_run = 0; end
            low_run++;
        end
        ms_prev = mdio_start;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input bit wr, input logic [4:0] p, input logic [4:0] r,
                           input logic [15:0] d);
        req_write[id] = wr; req_phyad[5*id +: 5] = p; req_regad[5*id +: 5] = r;
        req_wdata[16*id +: 16] = d; req_valid[id] = 1'b1;
    endtask

    task automatic await_ready(input int id, input int budget);
        int n = 0;
        #1;
        while (!req_ready[id] && n < budget) begin tick(); n++; end
        chk($sformatf("grant_req%0d", id), req_ready[id], 1);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic await_ms(input int budget);
        int n = 0;
        while (!mdio_start && n < budget) begin tick(); n++; end
        chk("frame_start_seen", mdio_start, 1);
    endtask

    task automatic await_rsp(input int id, input int budget, input logic [15:0] rd, input bit er);
        int n = 0;
        while (!rsp_valid[id] && n < budget) begin tick(); n++; end
        chk($sformatf("rsp_seen_req%0d", id), rsp_valid[id], 1);
        chk($sformatf("rsp_rdata_req%0d", id), rsp_rdata, rd);
        chk($sformatf("rsp_err_req%0d", id), rsp_err, er);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_write = '0; req_phyad = '0; req_regad = '0;
        req_wdata = '0; rd_data = '0; data_rdy = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);

        // Write from req0, with a stray data_rdy mid-frame that must be ignored.
        set_req(0, 1, 5'h01, 5'h00, 16'h8000);
        await_ready(0, 50);
        await_ms(10);
        tick(10); data_rdy = 1'b1; rd_data = 16'hBEEF; tick(); data_rdy = 1'b0;
        await_rsp(0, 300, 16'h0000, 0);
        chk("wr_frame", cap_frame, 32'h5082_8000);
        chk("wr_len", ms_len, 128);

        // Same requester again, back to back.
        set_req(0, 1, 5'h00, 5'h00, 16'h8000);
        await_ready(0, 50);
        await_rsp(0, 300, 16'h0000, 0);
        chk("wr2_frame", cap_frame, 32'h5002_8000);

        // Read from req2, data returned on the 90th frame clock.
        set_req(2, 0, 5'h03, 5'h02, 16'hFFFF);
        await_ready(2, 50);
        await_ms(10);
        tick(89); data_rdy = 1'b1; rd_data = 16'h0141; tick(); data_rdy = 1'b0;
        await_rsp(2, 50, 16'h0141, 0);
        chk("rd_frame", cap_frame, 32'h6188_0000);
        chk("rd_len", ms_len, 90);

        // Read timeout.
        set_req(1, 0, 5'h1F, 5'h1F, 16'h0);
        await_ready(1, 50);
        await_rsp(1, 400, 16'h0000, 1);
        chk("tmo_len", ms_len, 256);
        chk("tmo_frame", cap_frame, 32'h6FFC_0000);

        // Data on the expiry clock wins over the timeout.
        set_req(3, 0, 5'h02, 5'h03, 16'h0);
        await_ready(3, 50);
        await_ms(10);
        tick(255); data_rdy = 1'b1; rd_data = 16'hA5A5; tick(); data_rdy = 1'b0;
        await_rsp(3, 50, 16'hA5A5, 0);
        chk("edge_len", ms_len, 256);

        // Reset in the middle of a write frame.
        tick(GAPC + 2);
        set_req(3, 1, 5'h04, 5'h05, 16'h1234);
        await_ready(3, 50);
        await_ms(10);
        tick(50);
        reset = 1'b1;
        #1;
        chk("async_rst_mdio_start", mdio_start, 0);
        chk("async_rst_busy", busy, 0);
        tick(2);
        reset = 1'b0;

        // Fairness with every requester holding a request.
        grants.delete(); seen_fall = 0; min_gap = 1000000;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 5'(i + 4), 5'(i), 16'(16'h1000 * i));
        begin
            int n = 0;
            while (grants.size() < 5 && n < 2000) begin tick(); n++; end
        end
        req_valid = '0;
        chk("fair_count", grants.size(), 5);
        if (grants.size() >= 5) begin
            chk("fair_g0", grants[0], 0);
            chk("fair_g1", grants[1], 1);
            chk("fair_g2", grants[2], 2);
            chk("fair_g3", grants[3], 3);
            chk("fair_g4", grants[4], 0);
        end
        chk("fair_gap_ok", (min_gap >= GAPC) ? 1 : 0, 1);
        await_rsp(0, 400, 16'h0000, 0);
        tick(GAPC + 2);

        // Withdraw: req1 drops before being served, req3 goes next.
        grants.delete();
        set_req(0, 1, 5'h01, 5'h01, 16'h0001);
        await_ready(0, 50);
        set_req(1, 0, 5'h02, 5'h02, 16'h0);
        set_req(3, 1, 5'h03, 5'h03, 16'h0003);
        await_ms(10);
        tick(20);
        req_valid[1] = 1'b0;
        await_rsp(0, 300, 16'h0000, 0);
        await_ready(3, 50);
        await_rsp(3, 300, 16'h0000, 0);
        chk("wd_count", grants.size(), 2);
        if (grants.size() >= 2) begin
            chk("wd_g0", grants[0], 0);
            chk("wd_g1", grants[1], 3);
        end

        tick(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
